// File: rtl/timer_seq_ctrl_if.sv
// Control/CSR-side bundle for the interval timer.
// The master drives config and commands; the timer (slave) reports status.
interface timer_seq_ctrl_if #(
  parameter int N  = 8,
  parameter int PW = 4
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [N-1:0]  cfg_period;
  logic [PW-1:0] cfg_presc;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic          irq_clr;
  logic          busy;
  logic [N-1:0]  count;
  logic          done;
  logic          irq;

  modport master (
    output cfg_valid, cfg_period, cfg_presc, cfg_periodic,
    output start, stop, irq_clr,
    input  cfg_ready, busy, count, done, irq
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_presc, cfg_periodic,
    input  start, stop, irq_clr,
    output cfg_ready, busy, count, done, irq
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Programmable interval timer: prescaled up-counter with IDLE/RUN/PAUSE
// sequencing, one-cycle terminal-count pulse and sticky interrupt.
module timer_seq_ctrl #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  timer_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  count, count_n;
  logic [N-1:0]  period_r;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [PW-1:0] presc_r;
  logic          periodic_r;
  logic          done, done_n;
  logic          irq, irq_n;
  logic          en;
  logic          term;
  logic          cfg_fire;

  assign cfg_fire = bus.cfg_valid && (state == IDLE);

  // stop beats a prescaler tick on the same edge
  assign en   = (state == RUN) && (pcnt == presc_r) && !bus.stop;
  assign term = en && (count == period_r - N'(1));

  always_comb begin
    state_n = state;
    count_n = count;
    pcnt_n  = pcnt;
    done_n  = 1'b0;
    irq_n   = irq && !bus.irq_clr;
    unique case (state)
      IDLE: begin
        if (bus.start && (period_r != '0)) begin
          state_n = RUN;
          count_n = '0;
          pcnt_n  = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = PAUSE;
        end else if (en) begin
          pcnt_n = '0;
          if (term) begin
            count_n = '0;
            done_n  = 1'b1;
            irq_n   = 1'b1;
            if (!periodic_r) state_n = IDLE;
          end else begin
            count_n = count + N'(1);
          end
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_n = IDLE;
          count_n = '0;
          pcnt_n  = '0;
        end else if (bus.start) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        pcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pcnt  <= '0;
      done  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      pcnt  <= pcnt_n;
      done  <= done_n;
      irq   <= irq_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r   <= '0;
      presc_r    <= '0;
      periodic_r <= 1'b0;
    end else if (cfg_fire) begin
      period_r   <= bus.cfg_period;
      presc_r    <= bus.cfg_presc;
      periodic_r <= bus.cfg_periodic;
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.count     = count;
  assign bus.done      = done;
  assign bus.irq       = irq;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed self-checking bench for timer_seq_ctrl.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_timer_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  timer_seq_ctrl_if #(.N(8), .PW(4)) bus ();

  timer_seq_ctrl #(.N(8), .PW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] s,
                           input logic per);
    bus.cfg_valid    = 1'b1;
    bus.cfg_period   = p;
    bus.cfg_presc    = s;
    bus.cfg_periodic = per;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", bus.count);
    end
    checks++;
    if ({bus.done, bus.irq, bus.busy, bus.cfg_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0001",
               {bus.done, bus.irq, bus.busy, bus.cfg_ready});
    end
  endtask

  task automatic test_oneshot();
    configure(8'd5, 4'd0, 1'b0);
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL os_start busy=%b count=%0d exp 1/0", bus.busy, bus.count);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.count !== 8'(k) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL os_step%0d count=%0d done=%b exp %0d/0",
                 k, bus.count, bus.done, k);
      end
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.irq} !== 3'b101 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL os_term done/busy/irq=%b count=%0d exp 101/0",
               {bus.done, bus.busy, bus.irq}, bus.count);
    end
    clear_irq();
    checks++;
    if (bus.irq !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL os_clr irq=%b done=%b exp 0/0", bus.irq, bus.done);
    end
  endtask

  task automatic test_periodic();
    configure(8'd3, 4'd1, 1'b1);
    pulse_start();
    for (int e = 1; e <= 18; e++) begin
      bus.irq_clr = (e == 12);
      tick();
      bus.irq_clr = 1'b0;
      checks++;
      if (bus.done !== ((e % 6) == 0) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL per_edge%0d done=%b busy=%b exp %b/1",
                 e, bus.done, bus.busy, (e % 6) == 0);
      end
      if (e == 12) begin
        checks++;
        if (bus.irq !== 1'b1) begin
          errors++;
          $display("FAIL per_setwins irq=%b exp 1", bus.irq);
        end
      end
    end
    bus.stop = 1'b1;
    tick();
    tick();
    bus.stop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL per_abort busy=%b count=%0d exp 0/0", bus.busy, bus.count);
    end
    clear_irq();
  endtask

  task automatic test_pause();
    configure(8'd10, 4'd0, 1'b0);
    pulse_start();
    repeat (4) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.count !== 8'd4 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold%0d count=%0d busy=%b done=%b exp 4/1/0",
                 k, bus.count, bus.busy, bus.done);
      end
      tick();
    end
    pulse_start();
    repeat (5) tick();
    checks++;
    if (bus.count !== 8'd9 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL resume_pre count=%0d done=%b exp 9/0", bus.count, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL resume_term done=%b busy=%b exp 1/0", bus.done, bus.busy);
    end
    clear_irq();
    pulse_start();
    repeat (2) tick();
    bus.stop = 1'b1;
    tick();
    checks++;
    if (bus.count !== 8'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pause2 count=%0d busy=%b exp 2/1", bus.count, bus.busy);
    end
    tick();
    bus.stop = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.irq} !== 3'b000 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL abort busy/done/irq=%b count=%0d exp 000/0",
               {bus.busy, bus.done, bus.irq}, bus.count);
    end
  endtask

  task automatic test_config_guard();
    configure(8'd0, 4'd0, 1'b0);
    pulse_start();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_period busy=%b exp 0", bus.busy);
    end
    configure(8'd4, 4'd0, 1'b0);
    pulse_start();
    bus.cfg_valid  = 1'b1;
    bus.cfg_period = 8'd7;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (bus.cfg_ready !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL guard_edge%0d ready=%b done=%b exp 0/0",
                 e, bus.cfg_ready, bus.done);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL guard_term done=%b ready=%b exp 1/1",
               bus.done, bus.cfg_ready);
    end
    tick();
    bus.cfg_valid = 1'b0;
    pulse_start();
    repeat (6) tick();
    checks++;
    if (bus.count !== 8'd6 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL newcfg_pre count=%0d done=%b exp 6/0", bus.count, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL newcfg_term done=%b busy=%b exp 1/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    configure(8'd20, 4'd0, 1'b0);
    pulse_start();
    repeat (9) tick();
    checks++;
    if (bus.count !== 8'd9 || bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre count=%0d irq=%b exp 9/1", bus.count, bus.irq);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.irq} !== 3'b000 || bus.count !== 8'd0) begin
      errors++;
      $display("FAIL ar_now busy/done/irq=%b count=%0d exp 000/0",
               {bus.busy, bus.done, bus.irq}, bus.count);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle ready=%b busy=%b done=%b exp 1/0/0",
               bus.cfg_ready, bus.busy, bus.done);
    end
    pulse_start();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_period_cleared busy=%b exp 0", bus.busy);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_period   = '0;
    bus.cfg_presc    = '0;
    bus.cfg_periodic = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.irq_clr      = 1'b0;
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_config_guard();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
